// File: rtl/alu_issue_if.sv
// ============================================================================
// alu_issue_if : instruction in, ALU drive/return, and writeback out bundle
// Revision     : 1.0
// ============================================================================
`default_nettype none

interface alu_issue_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [31:0]      rs1_val;
  logic [31:0]      rs2_val;
  logic [31:0]      alu_dataa;
  logic [31:0]      alu_datab;
  logic [3:0]       alu_ctr;
  logic [31:0]      alu_result;
  logic             alu_zero;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic             out_zero;
  logic [4:0]       out_rd;
  logic             out_wen;
  logic             out_illegal;
  logic [CNT_W-1:0] retired_cnt;

  // Environment side: issues instructions, acts as the ALU, consumes results
  modport master (
    output in_valid, instr, rs1_val, rs2_val, alu_result, alu_zero, out_ready,
    input  in_ready, alu_dataa, alu_datab, alu_ctr, out_valid, out_result,
           out_zero, out_rd, out_wen, out_illegal, retired_cnt
  );

  modport slave (
    input  in_valid, instr, rs1_val, rs2_val, alu_result, alu_zero, out_ready,
    output in_ready, alu_dataa, alu_datab, alu_ctr, out_valid, out_result,
           out_zero, out_rd, out_wen, out_illegal, retired_cnt
  );
endinterface

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
// ============================================================================
// alu_issue_ctrl : RV32I ALU-op decode/issue front end with result hold stage
// Revision       : 1.0
// ============================================================================
`default_nettype none

module alu_issue_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  alu_issue_if.slave  bus
);

  localparam logic [6:0]       C_OP_R    = 7'b0110011;
  localparam logic [6:0]       C_OP_I    = 7'b0010011;
  localparam logic [6:0]       C_OP_LUI  = 7'b0110111;
  localparam logic [6:0]       C_F7_BASE = 7'b0000000;
  localparam logic [6:0]       C_F7_ALT  = 7'b0100000;
  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_accept;
  logic             w_out_hs;

  logic [6:0]       w_opcode;
  logic [2:0]       w_f3;
  logic [6:0]       w_f7;
  logic [31:0]      w_imm_i;
  logic             w_legal;
  logic [3:0]       w_ctr;
  logic [31:0]      w_a;
  logic [31:0]      w_b;

  logic [3:0]       r_alu_ctr;
  logic [31:0]      r_alu_dataa;
  logic [31:0]      r_alu_datab;
  logic [4:0]       r_pend_rd;
  logic             r_pend_legal;
  logic [31:0]      r_out_result;
  logic             r_out_zero;
  logic [4:0]       r_out_rd;
  logic             r_out_wen;
  logic             r_out_illegal;
  logic [CNT_W-1:0] r_cnt;

  assign w_opcode = bus.instr[6:0];
  assign w_f3     = bus.instr[14:12];
  assign w_f7     = bus.instr[31:25];
  assign w_imm_i  = {{20{bus.instr[31]}}, bus.instr[31:20]};

  // Decode; illegal instructions are sent through EXEC as a zeroed add
  always_comb begin
    w_legal = 1'b0;
    w_ctr   = {1'b0, w_f3};
    w_a     = 32'd0;
    w_b     = 32'd0;
    case (w_opcode)
      C_OP_R: begin
        w_legal = (w_f7 == C_F7_BASE) ||
                  ((w_f7 == C_F7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
        w_ctr[3] = bus.instr[30] && ((w_f3 == 3'b000) || (w_f3 == 3'b101));
        w_a      = bus.rs1_val;
        w_b      = bus.rs2_val;
      end
      C_OP_I: begin
        if (w_f3 == 3'b001) begin
          w_legal = (w_f7 == C_F7_BASE);
        end else if (w_f3 == 3'b101) begin
          w_legal = (w_f7 == C_F7_BASE) || (w_f7 == C_F7_ALT);
        end else begin
          w_legal = 1'b1;
        end
        // ADDI ignores bit 30; only the right shift uses it to pick SRA
        w_ctr[3] = bus.instr[30] && (w_f3 == 3'b101);
        w_a      = bus.rs1_val;
        w_b      = w_imm_i;
      end
      C_OP_LUI: begin
        w_legal = 1'b1;
        w_ctr   = 4'b1111;
        w_a     = 32'd0;
        w_b     = {bus.instr[31:12], 12'd0};
      end
      default: w_legal = 1'b0;
    endcase
    if (!w_legal) begin
      w_ctr = 4'b0000;
      w_a   = 32'd0;
      w_b   = 32'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        w_in_ready  = bus.out_ready;
        if (bus.out_ready) w_state_nxt = bus.in_valid ? S_EXEC : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_accept = bus.in_valid & w_in_ready;
  assign w_out_hs = w_out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_ctr     <= 4'd0;
      r_alu_dataa   <= 32'd0;
      r_alu_datab   <= 32'd0;
      r_pend_rd     <= 5'd0;
      r_pend_legal  <= 1'b0;
      r_out_result  <= 32'd0;
      r_out_zero    <= 1'b0;
      r_out_rd      <= 5'd0;
      r_out_wen     <= 1'b0;
      r_out_illegal <= 1'b0;
      r_cnt         <= '0;
    end else begin
      if (w_accept) begin
        r_alu_ctr    <= w_ctr;
        r_alu_dataa  <= w_a;
        r_alu_datab  <= w_b;
        r_pend_rd    <= bus.instr[11:7];
        r_pend_legal <= w_legal;
      end
      if (r_state == S_EXEC) begin
        r_out_result  <= r_pend_legal ? bus.alu_result : 32'd0;
        r_out_zero    <= r_pend_legal ? bus.alu_zero : 1'b1;
        r_out_rd      <= r_pend_rd;
        r_out_wen     <= r_pend_legal && (r_pend_rd != 5'd0);
        r_out_illegal <= !r_pend_legal;
      end
      if (w_out_hs && !r_out_illegal) begin
        r_cnt <= r_cnt + C_CNT_ONE;
      end
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_out_valid;
  assign bus.alu_ctr     = r_alu_ctr;
  assign bus.alu_dataa   = r_alu_dataa;
  assign bus.alu_datab   = r_alu_datab;
  assign bus.out_result  = r_out_result;
  assign bus.out_zero    = r_out_zero;
  assign bus.out_rd      = r_out_rd;
  assign bus.out_wen     = r_out_wen;
  assign bus.out_illegal = r_out_illegal;
  assign bus.retired_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// ============================================================================
// tb_alu_issue_ctrl : directed bench with ISA-level reference model and ALU
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_alu_issue_ctrl;

  localparam int CNT_W = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_issue_if #(.CNT_W(CNT_W)) bus ();

  alu_issue_ctrl #(.CNT_W(CNT_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External ALU behaviour driven by the block's registered outputs
  always_comb begin
    bus.alu_result = 32'd0;
    case (bus.alu_ctr)
      4'b0000: bus.alu_result = bus.alu_dataa + bus.alu_datab;
      4'b1000: bus.alu_result = bus.alu_dataa - bus.alu_datab;
      4'b0001: bus.alu_result = bus.alu_dataa << bus.alu_datab[4:0];
      4'b0010: bus.alu_result = {31'd0, $signed(bus.alu_dataa) < $signed(bus.alu_datab)};
      4'b0011: bus.alu_result = {31'd0, bus.alu_dataa < bus.alu_datab};
      4'b0100: bus.alu_result = bus.alu_dataa ^ bus.alu_datab;
      4'b0101: bus.alu_result = bus.alu_dataa >> bus.alu_datab[4:0];
      4'b1101: bus.alu_result = $signed(bus.alu_dataa) >>> bus.alu_datab[4:0];
      4'b0110: bus.alu_result = bus.alu_dataa | bus.alu_datab;
      4'b0111: bus.alu_result = bus.alu_dataa & bus.alu_datab;
      4'b1111: bus.alu_result = bus.alu_datab;
      default: bus.alu_result = 32'd0;
    endcase
    bus.alu_zero = (bus.alu_result == 32'd0);
  end

  typedef struct packed {
    logic        legal;
    logic [3:0]  ctr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    logic [4:0]  rd;
    logic        wen;
  } op_t;

  // Architectural meaning of an instruction, from mnemonic down
  function automatic op_t ref_op(input logic [31:0] ins, input logic [31:0] x, input logic [31:0] y);
    op_t         o;
    logic [2:0]  f3;
    logic [6:0]  f7;
    string       mn;
    o  = '0;
    f3 = ins[14:12];
    f7 = ins[31:25];
    mn = "";
    o.rd = ins[11:7];
    case (ins[6:0])
      7'b0110011: begin
        o.a = x; o.b = y;
        if (f7 == 7'h00) begin
          case (f3)
            3'd0: mn = "add";  3'd1: mn = "sll"; 3'd2: mn = "slt"; 3'd3: mn = "sltu";
            3'd4: mn = "xor";  3'd5: mn = "srl"; 3'd6: mn = "or";  default: mn = "and";
          endcase
        end else if (f7 == 7'h20 && f3 == 3'd0) mn = "sub";
        else if (f7 == 7'h20 && f3 == 3'd5) mn = "sra";
      end
      7'b0010011: begin
        o.a = x; o.b = {{20{ins[31]}}, ins[31:20]};
        case (f3)
          3'd0: mn = "add";  3'd2: mn = "slt"; 3'd3: mn = "sltu"; 3'd4: mn = "xor";
          3'd6: mn = "or";   3'd7: mn = "and";
          3'd1: mn = (f7 == 7'h00) ? "sll" : "";
          default: mn = (f7 == 7'h00) ? "srl" : (f7 == 7'h20) ? "sra" : "";
        endcase
      end
      7'b0110111: begin
        o.a = 32'd0; o.b = {ins[31:12], 12'd0}; mn = "lui";
      end
      default: mn = "";
    endcase
    case (mn)
      "add":  begin o.ctr = 4'd0;  o.res = o.a + o.b; end
      "sub":  begin o.ctr = 4'd8;  o.res = o.a - o.b; end
      "sll":  begin o.ctr = 4'd1;  o.res = o.a << o.b[4:0]; end
      "slt":  begin o.ctr = 4'd2;  o.res = ($signed(o.a) < $signed(o.b)) ? 32'd1 : 32'd0; end
      "sltu": begin o.ctr = 4'd3;  o.res = (o.a < o.b) ? 32'd1 : 32'd0; end
      "xor":  begin o.ctr = 4'd4;  o.res = o.a ^ o.b; end
      "srl":  begin o.ctr = 4'd5;  o.res = o.a >> o.b[4:0]; end
      "sra":  begin o.ctr = 4'd13; o.res = $signed(o.a) >>> o.b[4:0]; end
      "or":   begin o.ctr = 4'd6;  o.res = o.a | o.b; end
      "and":  begin o.ctr = 4'd7;  o.res = o.a & o.b; end
      "lui":  begin o.ctr = 4'd15; o.res = o.b; end
      default: ;
    endcase
    if (mn == "") begin
      o.a = 32'd0; o.b = 32'd0; o.ctr = 4'd0; o.res = 32'd0;
      o.zero = 1'b1; o.wen = 1'b0; o.legal = 1'b0;
    end else begin
      o.legal = 1'b1;
      o.zero  = (o.res == 32'd0);
      o.wen   = (o.rd != 5'd0);
    end
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an op spends one cycle executing, then waits to be taken
  op_t  m_pend;
  op_t  m_cur;
  logic m_exec;
  logic m_done;
  int   m_cnt;
  logic m_in_ready;
  logic m_acc;
  logic m_hs;

  assign m_in_ready = !m_exec && (!m_done || bus.out_ready);
  assign m_acc      = bus.in_valid && m_in_ready;
  assign m_hs       = m_done && bus.out_ready;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_exec <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
      m_pend <= '0;
      m_cur  <= '0;
    end else begin
      if (m_hs && m_cur.legal) m_cnt <= m_cnt + 1;
      m_exec <= m_acc;
      m_done <= m_exec || (m_done && !m_hs);
      if (m_exec) m_cur <= m_pend;
      if (m_acc) m_pend <= ref_op(bus.instr, bus.rs1_val, bus.rs2_val);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", 32'(bus.in_ready), 32'(m_in_ready));
      chk("out_valid", 32'(bus.out_valid), 32'(m_done));
      chk("retired_cnt", 32'(bus.retired_cnt), 32'(m_cnt % (1 << CNT_W)));
      if (m_exec) begin
        chk("alu_ctr", 32'(bus.alu_ctr), 32'(m_pend.ctr));
        chk("alu_dataa", bus.alu_dataa, m_pend.a);
        chk("alu_datab", bus.alu_datab, m_pend.b);
      end
      if (m_done) begin
        chk("out_result", bus.out_result, m_cur.res);
        chk("out_zero", 32'(bus.out_zero), 32'(m_cur.zero));
        chk("out_rd", 32'(bus.out_rd), 32'(m_cur.rd));
        chk("out_wen", 32'(bus.out_wen), 32'(m_cur.wen));
        chk("out_illegal", 32'(bus.out_illegal), 32'(!m_cur.legal));
      end
    end
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents an op and returns 1 time unit after the edge that accepted it
  task automatic send(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    logic rdy;
    bit   ok;
    ok = 0;
    bus.in_valid = 1'b1;
    bus.instr    = ins;
    bus.rs1_val  = a;
    bus.rs2_val  = b;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  logic [31:0] held_res;

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.instr     = 32'd0;
    bus.rs1_val   = 32'd0;
    bus.rs2_val   = 32'd0;
    bus.out_ready = 1'b0;

    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_alu_ctr", 32'(bus.alu_ctr), 32'd0);
    chk("rst_out_result", bus.out_result, 32'd0);
    chk("rst_cnt", 32'(bus.retired_cnt), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    // ADD x3,x1,x2
    bus.out_ready = 1'b1;
    step();
    send(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'd5, 32'd7);
    @(negedge clk);
    chk("add_ctr", 32'(bus.alu_ctr), 32'h0);
    chk("add_a", bus.alu_dataa, 32'd5);
    chk("add_b", bus.alu_datab, 32'd7);
    chk("exec_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("add_valid", 32'(bus.out_valid), 32'd1);
    chk("add_res", bus.out_result, 32'd12);
    chk("add_rd", 32'(bus.out_rd), 32'd3);
    chk("add_wen", 32'(bus.out_wen), 32'd1);
    @(negedge clk);
    chk("add_cnt", 32'(bus.retired_cnt), 32'd1);

    // SUB x0,x1,x2
    step();
    send(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd0), 32'h1234, 32'h1234);
    @(negedge clk);
    chk("sub_ctr", 32'(bus.alu_ctr), 32'h8);
    @(negedge clk);
    chk("sub_res", bus.out_result, 32'd0);
    chk("sub_zero", 32'(bus.out_zero), 32'd1);
    chk("sub_wen", 32'(bus.out_wen), 32'd0);

    // SRAI x5,x6,4 and LUI x7,0xABCDE
    step();
    send(enc_i(12'h404, 5'd6, 3'd5, 5'd5), 32'h8000_0000, 32'd0);
    @(negedge clk);
    chk("srai_ctr", 32'(bus.alu_ctr), 32'hD);
    chk("srai_b", bus.alu_datab, 32'h0000_0404);
    @(negedge clk);
    chk("srai_res", bus.out_result, 32'hF800_0000);
    step();
    send({20'hABCDE, 5'd7, 7'b0110111}, 32'h5555_5555, 32'd1);
    @(negedge clk);
    chk("lui_ctr", 32'(bus.alu_ctr), 32'hF);
    chk("lui_a", bus.alu_dataa, 32'd0);
    chk("lui_b", bus.alu_datab, 32'hABCD_E000);
    @(negedge clk);
    chk("lui_res", bus.out_result, 32'hABCD_E000);

    // Illegal opcode, rd=4
    step();
    send(32'h0000_027F, 32'd9, 32'd9);
    @(negedge clk);
    chk("ill_ctr", 32'(bus.alu_ctr), 32'h0);
    chk("ill_a", bus.alu_dataa, 32'd0);
    @(negedge clk);
    chk("ill_flag", 32'(bus.out_illegal), 32'd1);
    chk("ill_res", bus.out_result, 32'd0);
    chk("ill_zero", 32'(bus.out_zero), 32'd1);
    chk("ill_wen", 32'(bus.out_wen), 32'd0);
    chk("ill_rd", 32'(bus.out_rd), 32'd4);
    @(negedge clk);
    chk("ill_cnt", 32'(bus.retired_cnt), 32'd4);

    // MUL-encoded R-type, illegal shift immediate, then assorted legal ops
    step();
    send(enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd1), 32'd3, 32'd4);
    @(negedge clk);
    @(negedge clk);
    chk("mul_illegal", 32'(bus.out_illegal), 32'd1);
    step();
    send(enc_i(12'h405, 5'd1, 3'd1, 5'd2), 32'd1, 32'd0);
    step(); step();
    send(enc_i(12'hFFF, 5'd1, 3'd4, 5'd8), 32'h0F0F_0F0F, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("xori_res", bus.out_result, 32'hF0F0_F0F0);
    step();
    send(enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd9), 32'd1, 32'hFFFF_FFFF);
    step(); step();
    send(enc_i(12'hFFE, 5'd1, 3'd2, 5'd9), 32'hFFFF_FFF0, 32'd0);
    step(); step();
    send(enc_r(7'h20, 5'd2, 5'd1, 3'd5, 5'd11), 32'h8000_00F0, 32'd36);
    step(); step();
    send(enc_i(12'h01F, 5'd1, 3'd1, 5'd12), 32'd3, 32'd0);
    step(); step();
    send(enc_r(7'h20, 5'd2, 5'd1, 3'd4, 5'd13), 32'd1, 32'd2);
    step(); step();

    // Backpressure: result must hold, then a new op rides the release edge
    bus.out_ready = 1'b0;
    send(enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd9), 32'hF0, 32'h0F);
    @(negedge clk);
    @(negedge clk);
    held_res = bus.out_result;
    chk("bp_res", held_res, 32'hFF);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_hold", bus.out_result, held_res);
    end
    step();
    bus.out_ready = 1'b1;
    send(enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd10), 32'hFF, 32'h3C);
    @(negedge clk);
    chk("b2b_exec_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("b2b_valid", 32'(bus.out_valid), 32'd1);
    chk("b2b_res", bus.out_result, 32'h3C);

    // Reset while an op is executing
    step();
    send(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'd1, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_cnt", 32'(bus.retired_cnt), 32'd0);
    chk("mid_rst_ctr", 32'(bus.alu_ctr), 32'd0);
    chk("mid_rst_res", bus.out_result, 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Sixteen legal ops wrap the 4-bit counter back to zero
    for (int k = 0; k < 16; k++) begin
      step();
      if (k == 15) begin
        #1;
        chk("cnt_15", 32'(bus.retired_cnt), 32'd15);
      end
      send(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd1), 32'(k), 32'd1);
      @(negedge clk);
      @(negedge clk);
    end
    step();
    @(negedge clk);
    chk("cnt_wrap", 32'(bus.retired_cnt), 32'd0);

    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
